// File: rtl/dht11_reader.sv
// DHT11 host-side reader: issues the start pulse, follows the response handshake and captures the 40-bit frame.
// Optional macro DHT_CHECKSUM_CHECK_EN enables the checksum verdict (error code 11) in the CHECK state.
module dht11_reader #(
  parameter int START_LOW_US     = 18000,
  parameter int TIMEOUT_US       = 100,
  parameter int BIT_THRESHOLD_US = 40
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        microssegundo_i,
  input  logic        start_i,
  input  logic        dht_in_i,
  output logic        dht_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  error_code_o,
  output logic [39:0] data_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_FIN,
    S_ERR
  } state_e;

  localparam logic [14:0] StartLowCnt = 15'(START_LOW_US);
  localparam logic [14:0] TimeoutLast = 15'(TIMEOUT_US - 1);
  localparam logic [14:0] BitThresh   = 15'(BIT_THRESHOLD_US);

  state_e      state_q;
  logic [1:0]  msSync_q;
  logic        msPrev_q;
  logic [1:0]  dhtSync_q;
  logic        dhtPrev_q;
  logic [14:0] usCnt_q;
  logic [14:0] usCnt_d;
  logic [5:0]  bitIdx_q;
  logic [39:0] shift_q;
  logic [39:0] shift_d;
  logic [39:0] alignedShift;
  logic        tick;
  logic        dhtRise;
  logic        dhtFall;
  logic        timeoutHit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      msSync_q  <= '0;
      msPrev_q  <= 1'b0;
      dhtSync_q <= '0;
      dhtPrev_q <= 1'b0;
    end else begin
      msSync_q  <= {msSync_q[0], microssegundo_i};
      msPrev_q  <= msSync_q[1];
      dhtSync_q <= {dhtSync_q[0], dht_in_i};
      dhtPrev_q <= dhtSync_q[1];
    end
  end

  assign tick    = msSync_q[1] & ~msPrev_q;
  assign dhtRise = dhtSync_q[1] & ~dhtPrev_q;
  assign dhtFall = ~dhtSync_q[1] & dhtPrev_q;

  // The timeout fires on the very tick that would bring the count to TIMEOUT_US.
  assign timeoutHit = tick && (usCnt_q == TimeoutLast);

  assign usCnt_d = (tick && (usCnt_q != '1)) ? usCnt_q + 15'd1 : usCnt_q;
  assign shift_d = {shift_q[38:0], (usCnt_q > BitThresh)};

  // bitIdx_q counts bits already captured, so this left-aligns a partial frame.
  assign alignedShift = shift_q << (6'd40 - bitIdx_q);

`ifdef DHT_CHECKSUM_CHECK_EN
  logic [7:0] byteSum;
  logic       checksumBad;
  assign byteSum     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
  assign checksumBad = (byteSum != shift_q[7:0]);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      usCnt_q      <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      dht_oe_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      error_code_o <= 2'b00;
      data_o       <= '0;
    end else begin
      usCnt_q <= usCnt_d;
      done_o  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          dht_oe_o <= 1'b0;
          if (start_i) begin
            busy_o       <= 1'b1;
            error_o      <= 1'b0;
            error_code_o <= 2'b00;
            data_o       <= '0;
            shift_q      <= '0;
            bitIdx_q     <= '0;
            dht_oe_o     <= 1'b1;
            usCnt_q      <= '0;
            state_q      <= S_START_LOW;
          end
        end
        S_START_LOW: begin
          if (usCnt_q == StartLowCnt) begin
            dht_oe_o <= 1'b0;
            usCnt_q  <= '0;
            state_q  <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (dhtFall) begin
            usCnt_q <= '0;
            state_q <= S_RESP_LOW;
          end else if (timeoutHit) begin
            error_code_o <= 2'b01;
            usCnt_q      <= '0;
            state_q      <= S_ERR;
          end
        end
        S_RESP_LOW: begin
          if (dhtRise) begin
            usCnt_q <= '0;
            state_q <= S_RESP_HIGH;
          end else if (timeoutHit) begin
            error_code_o <= 2'b01;
            usCnt_q      <= '0;
            state_q      <= S_ERR;
          end
        end
        S_RESP_HIGH: begin
          if (dhtFall) begin
            bitIdx_q <= '0;
            usCnt_q  <= '0;
            state_q  <= S_BIT_LOW;
          end else if (timeoutHit) begin
            error_code_o <= 2'b01;
            usCnt_q      <= '0;
            state_q      <= S_ERR;
          end
        end
        S_BIT_LOW: begin
          if (dhtRise) begin
            usCnt_q <= '0;
            state_q <= S_BIT_HIGH;
          end else if (timeoutHit) begin
            error_code_o <= 2'b10;
            usCnt_q      <= '0;
            state_q      <= S_ERR;
          end
        end
        S_BIT_HIGH: begin
          // An edge landing on the timeout tick still counts as a valid bit.
          if (dhtFall) begin
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_q + 6'd1;
            usCnt_q  <= '0;
            state_q  <= (bitIdx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
          end else if (timeoutHit) begin
            error_code_o <= 2'b10;
            usCnt_q      <= '0;
            state_q      <= S_ERR;
          end
        end
        S_CHECK: begin
          data_o  <= shift_q;
          usCnt_q <= '0;
          state_q <= S_FIN;
`ifdef DHT_CHECKSUM_CHECK_EN
          if (checksumBad) begin
            error_code_o <= 2'b11;
            state_q      <= S_ERR;
          end
`endif
        end
        S_FIN: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          usCnt_q <= '0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          error_o <= 1'b1;
          data_o  <= alignedShift;
          usCnt_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          dht_oe_o <= 1'b0;
          busy_o   <= 1'b0;
          usCnt_q  <= '0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Self-checking bench for dht11_reader: scripted DHT11 sensor, table of directed frames and randomized frames.
// Honours DHT_CHECKSUM_CHECK_EN the same way the design does.
module tb_dht11_reader;

  localparam int START_US   = 30;
  localparam int TIMEOUT_US = 100;
  localparam int THRESH_US  = 40;
  localparam int CLK_PER_US = 4;

  localparam int K_FRAME  = 0;
  localparam int K_NORESP = 1;
  localparam int K_STOP   = 2;

  typedef struct {
    int          kind;
    logic [39:0] frame;
    int          stopBits;
    bit          boundary;
    bit          busyStart;
    logic        expErr;
    logic [1:0]  expCode;
    logic [39:0] expData;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms;
  logic        start;
  logic        sensorLevel;
  logic        dhtIn;
  logic        dhtOe;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  errorCode;
  logic [39:0] data;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          doneCount = 0;
  int          doneCycle = 0;
  logic        capErr;
  logic [1:0]  capCode;
  logic [39:0] capData;
  logic        capBusy;

  dht11_reader #(
    .START_LOW_US    (START_US),
    .TIMEOUT_US      (TIMEOUT_US),
    .BIT_THRESHOLD_US(THRESH_US)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .microssegundo_i(ms),
    .start_i        (start),
    .dht_in_i       (dhtIn),
    .dht_oe_o       (dhtOe),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .error_code_o   (errorCode),
    .data_o         (data)
  );

  // Open-drain line: host pulls low when enabled, otherwise the sensor (or pull-up) sets the level.
  assign dhtIn = dhtOe ? 1'b0 : sensorLevel;

  always #5 clk = ~clk;

  initial begin
    ms = 1'b0;
    forever begin
      repeat (CLK_PER_US / 2) @(negedge clk);
      ms = ~ms;
    end
  end

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (done) begin
      doneCount = doneCount + 1;
      doneCycle = cycle;
      capErr    = error;
      capCode   = errorCode;
      capData   = data;
      capBusy   = busy;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic waitUs(input int n);
    repeat (n) @(negedge ms);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [1:0] modelCode(input logic [39:0] d);
`ifdef DHT_CHECKSUM_CHECK_EN
    int sum;
    sum = d[39:32] + d[31:24] + d[23:16] + d[15:8];
    if ((sum % 256) != int'(d[7:0])) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic vec_t mkVec(input int kind, input logic [39:0] frame, input int stopBits,
                                 input bit boundary, input bit busyStart, input logic expErr,
                                 input logic [1:0] expCode, input logic [39:0] expData);
    vec_t v;
    v.kind      = kind;
    v.frame     = frame;
    v.stopBits  = stopBits;
    v.boundary  = boundary;
    v.busyStart = busyStart;
    v.expErr    = expErr;
    v.expCode   = expCode;
    v.expData   = expData;
    return v;
  endfunction

  // Runs one host transaction against a scripted sensor. modelData is what the bits the
  // sensor actually sent decode to (high phase longer than THRESH_US means 1).
  task automatic applyStimulus(input int kind, input logic [39:0] frame, input int stopBits,
                               input bit boundary, input bit busyStart, input string tag,
                               output logic [39:0] modelData, output int oeToDone);
    int hiUs[40];
    int nbits;
    int base;
    int oeCycle;
    for (int i = 0; i < 40; i++)
      hiUs[i] = frame[39 - i] ? int'($urandom_range(72, 65)) : int'($urandom_range(28, 24));
    if (boundary) begin
      hiUs[0] = THRESH_US;
      hiUs[1] = THRESH_US + 1;
    end
    nbits = (kind == K_FRAME) ? 40 : (kind == K_STOP) ? stopBits : 0;
    modelData = '0;
    for (int i = 0; i < nbits; i++)
      modelData[39 - i] = (hiUs[i] > THRESH_US);

    base = doneCount;
    pulseStart();
    checkOutput({tag, "_start_to_oe"}, dhtOe, 1'b1);
    checkOutput({tag, "_busy_set"}, busy, 1'b1);

    for (int c = 0; c < (START_US + 4) * CLK_PER_US && dhtOe; c++) @(negedge clk);
    checkOutput({tag, "_oe_release"}, dhtOe, 1'b0);
    oeCycle = cycle;

    if (kind == K_NORESP) begin
      if (busyStart) begin
        waitUs(20);
        pulseStart();
      end
    end else begin
      waitUs(20);
      sensorLevel = 1'b0;
      waitUs(80);
      sensorLevel = 1'b1;
      waitUs(80);
      sensorLevel = 1'b0;
      if (busyStart) pulseStart();
      for (int i = 0; i < nbits; i++) begin
        waitUs(8);
        sensorLevel = 1'b1;
        waitUs(hiUs[i]);
        sensorLevel = 1'b0;
      end
      if (kind == K_FRAME) begin
        waitUs(10);
        sensorLevel = 1'b1;
      end
    end

    for (int c = 0; c < 250 * CLK_PER_US && doneCount == base; c++) @(negedge clk);
    sensorLevel = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput({tag, "_done_pulses"}, 40'(doneCount - base), 40'd1);
    checkOutput({tag, "_busy_at_done"}, capBusy, 1'b0);
    oeToDone = doneCycle - oeCycle;
  endtask

  vec_t        vecs[5];
  logic [39:0] md;
  int          lat;
  logic [39:0] rnd;
  logic [7:0]  sumByte;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    sensorLevel = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("reset_oe", dhtOe, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_error", error, 1'b0);
    checkOutput("reset_code", errorCode, 2'b00);
    checkOutput("reset_data", data, 40'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    vecs[0] = mkVec(K_NORESP, 40'h0, 0, 1'b0, 1'b1, 1'b1, 2'b01, 40'h0);
    vecs[1] = mkVec(K_STOP, 40'h3700190050, 13, 1'b0, 1'b0, 1'b1, 2'b10, 40'h3700000000);
`ifdef DHT_CHECKSUM_CHECK_EN
    vecs[2] = mkVec(K_FRAME, 40'h3700190051, 0, 1'b0, 1'b0, 1'b1, 2'b11, 40'h3700190051);
`else
    vecs[2] = mkVec(K_FRAME, 40'h3700190051, 0, 1'b0, 1'b0, 1'b0, 2'b00, 40'h3700190051);
`endif
    vecs[3] = mkVec(K_FRAME, 40'h4000190059, 0, 1'b1, 1'b0, 1'b0, 2'b00, 40'h4000190059);
    vecs[4] = mkVec(K_FRAME, 40'h3700190050, 0, 1'b0, 1'b1, 1'b0, 2'b00, 40'h3700190050);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].frame, vecs[i].stopBits, vecs[i].boundary,
                    vecs[i].busyStart, $sformatf("row%0d", i), md, lat);
      checkOutput($sformatf("row%0d_error", i), capErr, vecs[i].expErr);
      checkOutput($sformatf("row%0d_code", i), capCode, vecs[i].expCode);
      checkOutput($sformatf("row%0d_data", i), capData, vecs[i].expData);
      if (vecs[i].kind == K_NORESP) begin
        // 100 us at 4 clk/us, allowing one us of tick phase uncertainty either way.
        checks = checks + 1;
        if (lat < (TIMEOUT_US - 1) * CLK_PER_US || lat > (TIMEOUT_US + 1) * CLK_PER_US) begin
          errors = errors + 1;
          $display("[TB] FAIL row%0d_timeout_latency: got %0d clk, expected %0d..%0d clk", i, lat,
                   (TIMEOUT_US - 1) * CLK_PER_US, (TIMEOUT_US + 1) * CLK_PER_US);
        end
      end
    end

    // Reset while the host is still driving the start pulse.
    pulseStart();
    repeat (10 * CLK_PER_US) @(negedge clk);
    checkOutput("pre_reset_oe", dhtOe, 1'b1);
    checkOutput("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_oe", dhtOe, 1'b0);
    checkOutput("mid_reset_busy", busy, 1'b0);
    checkOutput("mid_reset_error", error, 1'b0);
    checkOutput("mid_reset_code", errorCode, 2'b00);
    checkOutput("mid_reset_data", data, 40'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20 * CLK_PER_US) @(negedge clk);
    checkOutput("post_reset_oe", dhtOe, 1'b0);
    checkOutput("post_reset_done_count", 40'(doneCount), 40'd5);

    for (int r = 0; r < 2; r++) begin
      rnd[39:8] = $urandom;
      sumByte = rnd[39:32] + rnd[31:24] + rnd[23:16] + rnd[15:8];
      rnd[7:0] = ($urandom_range(1, 0) == 1) ? sumByte : sumByte ^ 8'(1 << $urandom_range(7, 0));
      applyStimulus(K_FRAME, rnd, 0, 1'b0, 1'b0, $sformatf("rand%0d", r), md, lat);
      checkOutput($sformatf("rand%0d_data", r), capData, md);
      checkOutput($sformatf("rand%0d_code", r), capCode, modelCode(md));
      checkOutput($sformatf("rand%0d_error", r), capErr, modelCode(md) != 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
